// File: rtl/moore_1011.sv
// Moore detector for the serial pattern 1-0-1-1 with overlap.
// The match output is registered from the next-state decode, so it is high exactly while the FSM sits in S4.
module moore_1011 (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic dout_moore
);

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;

    // State register and registered match decode; reset discards any partial prefix
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S0;
            dout_moore <= 1'b0;
        end else begin
            state_q    <= state_d;
            dout_moore <= (state_d == S4);
        end
    end

    // Next-state logic; S4 reuses its trailing 1 as the start of the next match
    always_comb begin
        state_d = S0;
        case (state_q)
            S0:      state_d = din ? S1 : S0;
            S1:      state_d = din ? S1 : S2;
            S2:      state_d = din ? S3 : S0;
            S3:      state_d = din ? S4 : S2;
            S4:      state_d = din ? S1 : S2;
            default: state_d = S0;
        endcase
    end

endmodule

// File: tb/tb_moore_1011.sv
// Directed and randomized checks of moore_1011 against hand-computed values and a shift-register history model.
module tb_moore_1011;

    logic clk;
    logic rstn;
    logic din;
    logic dout_moore;

    int total;
    int bad;
    logic [3:0] hist;

    moore_1011 dut (
        .clk        (clk),
        .rstn       (rstn),
        .din        (din),
        .dout_moore (dout_moore)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one bit on the falling edge, clock it in, then check the output just after the rising edge
    task automatic step(input logic r, input logic d, input logic exp, input string tag);
        @(negedge clk);
        rstn = r;
        din  = d;
        @(posedge clk);
        #1;
        total++;
        assert (dout_moore === exp)
        else begin
            bad++;
            $error("FAIL %s: dout_moore=%b expected=%b", tag, dout_moore, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        din   = 1'b1;

        // 1) reset held with din=1
        step(1'b0, 1'b1, 1'b0, "rst_hold_0");
        step(1'b0, 1'b1, 1'b0, "rst_hold_1");

        // 2) single match 1,0,1,1,0
        step(1'b1, 1'b1, 1'b0, "single_b1");
        step(1'b1, 1'b0, 1'b0, "single_b2");
        step(1'b1, 1'b1, 1'b0, "single_b3");
        step(1'b1, 1'b1, 1'b1, "single_b4");
        step(1'b1, 1'b0, 1'b0, "single_b5");

        // 3) overlapped matches 1,0,1,1,0,1,1
        step(1'b0, 1'b0, 1'b0, "ovl_rst");
        step(1'b1, 1'b1, 1'b0, "ovl_b1");
        step(1'b1, 1'b0, 1'b0, "ovl_b2");
        step(1'b1, 1'b1, 1'b0, "ovl_b3");
        step(1'b1, 1'b1, 1'b1, "ovl_b4");
        step(1'b1, 1'b0, 1'b0, "ovl_b5");
        step(1'b1, 1'b1, 1'b0, "ovl_b6");
        step(1'b1, 1'b1, 1'b1, "ovl_b7");

        // 4) no match 1,1,1,1,0,0,1,0,0
        step(1'b0, 1'b0, 1'b0, "nom_rst");
        step(1'b1, 1'b1, 1'b0, "nom_b1");
        step(1'b1, 1'b1, 1'b0, "nom_b2");
        step(1'b1, 1'b1, 1'b0, "nom_b3");
        step(1'b1, 1'b1, 1'b0, "nom_b4");
        step(1'b1, 1'b0, 1'b0, "nom_b5");
        step(1'b1, 1'b0, 1'b0, "nom_b6");
        step(1'b1, 1'b1, 1'b0, "nom_b7");
        step(1'b1, 1'b0, 1'b0, "nom_b8");
        step(1'b1, 1'b0, 1'b0, "nom_b9");

        // 5) reset mid-sequence after 1,0,1, then 1 -> no pulse; then 1,0,1,1 -> pulse
        step(1'b0, 1'b0, 1'b0, "mid_rst0");
        step(1'b1, 1'b1, 1'b0, "mid_b1");
        step(1'b1, 1'b0, 1'b0, "mid_b2");
        step(1'b1, 1'b1, 1'b0, "mid_b3");
        step(1'b0, 1'b1, 1'b0, "mid_rst1");
        step(1'b1, 1'b1, 1'b0, "mid_after");
        step(1'b1, 1'b1, 1'b0, "mid_c1");
        step(1'b1, 1'b0, 1'b0, "mid_c2");
        step(1'b1, 1'b1, 1'b0, "mid_c3");
        step(1'b1, 1'b1, 1'b1, "mid_c4");

        // 6) random stream against a 4-bit history model, with occasional resets
        step(1'b0, 1'b0, 1'b0, "rnd_rst");
        hist = 4'b0000;
        for (int i = 0; i < 1000; i++) begin
            logic r;
            logic d;
            r = ($urandom_range(0, 63) != 0);
            d = 1'($urandom_range(0, 1));
            if (!r) hist = 4'b0000;
            else    hist = {hist[2:0], d};
            step(r, d, (hist == 4'b1011), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
